// File: rtl/modport_pkg.sv
// Shared widths and types for the modport_stream tap.
// HIST_DEPTH must be a power of two and at least 2 so the history pointer wraps for free.
// hist_entry_t: one history slot. val_a marks a slot written since reset, val_b marks a
// slot that has been overwritten at least once, value holds the accepted byte.
package modport_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned HIST_DEPTH = 4;
  localparam int unsigned CHK_W      = 16;

  typedef struct packed {
    logic              val_a;
    logic              val_b;
    logic [DATA_W-1:0] value;
  } hist_entry_t;

endpackage

// File: rtl/modport_stream_if.sv
// Stream bus for modport_stream.
// Modports:
//   master - producer/consumer side: drives valid, data, dword and downstream ready.
//   slave  - the tap itself: drives ready, accept strobe, data copies, address, history, sum.
//   source - read-only view of the captured address for downstream address consumers.
interface modport_stream_if;
  import modport_pkg::*;

  logic              stream_in_valid;
  logic              stream_in_ready;
  logic [DATA_W-1:0] stream_in_data;
  logic [ADDR_W-1:0] stream_in_data_dword;
  logic              stream_out_ready;
  logic [DATA_W-1:0] stream_out_data_comb;
  logic [DATA_W-1:0] stream_out_data_registered;
  logic              and_output;
  logic [ADDR_W-1:0] src_addr;
  logic [DATA_W-1:0] hist_last;
  logic [CHK_W-1:0]  checksum;

  modport master (
    output stream_in_valid, stream_in_data, stream_in_data_dword, stream_out_ready,
    input  stream_in_ready, stream_out_data_comb, stream_out_data_registered, and_output,
    input  src_addr, hist_last, checksum
  );

  modport slave (
    input  stream_in_valid, stream_in_data, stream_in_data_dword, stream_out_ready,
    output stream_in_ready, stream_out_data_comb, stream_out_data_registered, and_output,
    output src_addr, hist_last, checksum
  );

  modport source (
    input src_addr
  );

endinterface

// File: rtl/modport_hist.sv
// Circular history of accepted bytes; the oldest entry is silently overwritten.
// Ports:
//   clk, rst_n - clock and synchronous active-low reset (clears all entries and pointer)
//   wr_en      - write strobe (accepted transfer)
//   wr_data    - byte to store
//   hist_last  - most recently written byte (0 until the first write)
module modport_hist
  import modport_pkg::*;
#(
  parameter int unsigned Depth = HIST_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] hist_last
);

  localparam int unsigned PtrW = $clog2(Depth);

  hist_entry_t           hist_q [Depth];
  logic      [PtrW-1:0] wr_ptr_q;
  logic      [PtrW-1:0] rd_ptr;
  hist_entry_t           last_entry;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        hist_q[i] <= '0;
      end
    end else if (wr_en) begin
      hist_q[wr_ptr_q] <= '{val_a: 1'b1, val_b: hist_q[wr_ptr_q].val_a, value: wr_data};
      wr_ptr_q         <= wr_ptr_q + 1'b1;
    end
  end

  // Depth is a power of two, so pointer arithmetic wraps naturally.
  always_comb begin
    rd_ptr     = wr_ptr_q - 1'b1;
    last_entry = hist_q[rd_ptr];
    hist_last  = (last_entry.val_a | last_entry.val_b) ? last_entry.value : '0;
  end

endmodule

// File: rtl/modport_stream.sv
// Stream pass-through tap: forwards the byte combinationally and registered, mirrors
// downstream ready upstream, captures the address sideband on accept and keeps a short
// history of accepted bytes.
// Ports:
//   clk, rst_n - clock and synchronous active-low reset
//   bus        - modport_stream_if.slave (handshake, data copies, src_addr, hist_last, checksum)
// Build option: define MODPORT_CHECKSUM_EN to add a 16-bit wrapping sum of accepted bytes;
// without it checksum is tied to 0.
module modport_stream
  import modport_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  modport_stream_if.slave        bus
);

  logic              ready;
  logic              accept;
  logic [DATA_W-1:0] data_reg_q;
  logic [ADDR_W-1:0] src_addr_q;

  // Ready is gated by reset so nothing is accepted while reset is held.
  assign ready  = bus.stream_out_ready & rst_n;
  assign accept = ready & bus.stream_in_valid;

  assign bus.stream_in_ready            = ready;
  assign bus.and_output                 = accept;
  assign bus.stream_out_data_comb       = bus.stream_in_data;
  assign bus.stream_out_data_registered = data_reg_q;
  assign bus.src_addr                   = src_addr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_reg_q <= '0;
      src_addr_q <= '0;
    end else begin
      data_reg_q <= bus.stream_in_data;
      if (accept) begin
        src_addr_q <= bus.stream_in_data_dword;
      end
    end
  end

  modport_hist #(
    .Depth (HIST_DEPTH)
  ) u_hist (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (accept),
    .wr_data   (bus.stream_in_data),
    .hist_last (bus.hist_last)
  );

`ifdef MODPORT_CHECKSUM_EN
  logic [CHK_W-1:0] checksum_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      checksum_q <= '0;
    end else if (accept) begin
      checksum_q <= checksum_q + CHK_W'(bus.stream_in_data);
    end
  end

  assign bus.checksum = checksum_q;
`else
  assign bus.checksum = '0;
`endif

endmodule

// File: tb/tb_modport_stream.sv
module tb_modport_stream;
  import modport_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  modport_stream_if bus ();

  modport_stream u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic              rst_n;
    logic              valid;
    logic              ordy;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] dword;
    logic              exp_ready;
    logic              exp_and;
  } vec_t;

  typedef struct {
    logic [DATA_W-1:0] reg_data;
    logic [ADDR_W-1:0] src;
    logic [DATA_W-1:0] hist;
    logic [CHK_W-1:0]  chk;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  logic [DATA_W-1:0] m_hist [HIST_DEPTH];
  int unsigned       m_wp;
  logic [ADDR_W-1:0] m_src;
  logic [CHK_W-1:0]  m_chk;
  logic [DATA_W-1:0] m_reg;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // One clock: drive inputs, check zero-latency outputs, update model, then compare the
  // registered outputs against the scoreboard after the edge.
  task automatic cycle(input logic r, input logic v, input logic o, input logic [7:0] d,
                       input logic [31:0] dw, input logic e_rdy, input logic e_and,
                       input bit chk_hs);
    exp_t e;
    logic acc;
    rst_n                    = r;
    bus.stream_in_valid      = v;
    bus.stream_out_ready     = o;
    bus.stream_in_data       = d;
    bus.stream_in_data_dword = dw;
    #1;
    if (chk_hs) begin
      chk("in_ready", 32'(bus.stream_in_ready), 32'(e_rdy));
      chk("and_output", 32'(bus.and_output), 32'(e_and));
    end
    chk("data_comb", 32'(bus.stream_out_data_comb), 32'(d));
    acc = r & o & v;
    if (!r) begin
      m_reg = '0; m_src = '0; m_wp = 0; m_chk = '0;
      for (int i = 0; i < int'(HIST_DEPTH); i++) m_hist[i] = '0;
    end else begin
      m_reg = d;
      if (acc) begin
        m_src        = dw;
        m_hist[m_wp] = d;
        m_wp         = (m_wp + 1) % HIST_DEPTH;
        m_chk        = m_chk + CHK_W'(d);
      end
    end
    e.reg_data = m_reg;
    e.src      = m_src;
    e.hist     = m_hist[(m_wp + HIST_DEPTH - 1) % HIST_DEPTH];
`ifdef MODPORT_CHECKSUM_EN
    e.chk      = m_chk;
`else
    e.chk      = '0;
`endif
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("data_registered", 32'(bus.stream_out_data_registered), 32'(e.reg_data));
      chk("src_addr", bus.src_addr, e.src);
      chk("hist_last", 32'(bus.hist_last), 32'(e.hist));
      chk("checksum", 32'(bus.checksum), 32'(e.chk));
    end
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b1, 1'b1, 1'b0, 8'hA5, 32'hDEADBEEF, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 8'hA5, 32'hDEADBEEF, 1'b1, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 8'h3C, 32'h12345678, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 8'h77, 32'hCAFEF00D, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 8'h5A, 32'h00000001, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 8'h99, 32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 8'h11, 32'hAAAA5555, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 8'h22, 32'h00000000, 1'b0, 1'b0};

    // Reset held two cycles with upstream trying to push
    cycle(1'b0, 1'b1, 1'b1, 8'h00, 32'h0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 8'h00, 32'h0, 1'b0, 1'b0, 1'b1);

    foreach (vecs[i])
      cycle(vecs[i].rst_n, vecs[i].valid, vecs[i].ordy, vecs[i].data, vecs[i].dword,
            vecs[i].exp_ready, vecs[i].exp_and, 1'b1);

    // Address holds when the transfer is not accepted
    cycle(1'b1, 1'b1, 1'b1, 8'h01, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 8'h02, 32'h12345678, 1'b1, 1'b0, 1'b1);
    chk("src_addr_hold", bus.src_addr, 32'hDEADBEEF);

    // History wrap: bytes 1..5 into a depth-4 history
    cycle(1'b0, 1'b0, 1'b1, 8'h00, 32'h0, 1'b0, 1'b0, 1'b1);
    for (int b = 1; b <= 5; b++)
      cycle(1'b1, 1'b1, 1'b1, 8'(b), 32'(b), 1'b1, 1'b1, 1'b1);
    chk("hist_last_after_wrap", 32'(bus.hist_last), 32'd5);
`ifdef MODPORT_CHECKSUM_EN
    chk("checksum_1_to_5", 32'(bus.checksum), 32'd15);
`else
    chk("checksum_disabled", 32'(bus.checksum), 32'd0);
`endif

    // 258 accepts of 0xFF: 258*255 = 65790, which wraps to 0x00FE in 16 bits
    cycle(1'b0, 1'b0, 1'b1, 8'h00, 32'h0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 258; k++)
      cycle(1'b1, 1'b1, 1'b1, 8'hFF, 32'(k), 1'b1, 1'b1, 1'b0);
`ifdef MODPORT_CHECKSUM_EN
    chk("checksum_wrap", 32'(bus.checksum), 32'h00FE);
`else
    chk("checksum_wrap_disabled", 32'(bus.checksum), 32'd0);
`endif

    // Reset asserted while upstream presents an acceptable transfer
    cycle(1'b0, 1'b1, 1'b1, 8'h44, 32'h55555555, 1'b0, 1'b0, 1'b1);
    chk("checksum_after_reset", 32'(bus.checksum), 32'd0);
    chk("src_after_reset", bus.src_addr, 32'd0);
    chk("hist_after_reset", 32'(bus.hist_last), 32'd0);
    cycle(1'b1, 1'b1, 1'b1, 8'h66, 32'h01020304, 1'b1, 1'b1, 1'b1);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
